// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-port data memory.
// Port 0 is the CPU load/store unit and port 1 is the debug/loader port.
// A write completes in its grant cycle. A read spends one extra cycle in
// RD_WAIT while dmem presents dout. The data is then registered into the
// owning port's rdata with a one-cycle rvalid pulse.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | arbitration open; the winner drives dmem combinationally
// RD_WAIT | read outstanding, mem_dout valid this cycle; no grants issued
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  localparam int AW        = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  RESET,
  // requester 0
  input  logic                  req0,
  input  logic                  we0,
  input  logic [AW-1:0]         addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  // requester 1
  input  logic                  req1,
  input  logic                  we1,
  input  logic [AW-1:0]         addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  // dmem side
  output logic [AW-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last;      // port granted most recently; the other port wins a tie
  logic   owner;     // port that owns the outstanding read
  logic   accept0;
  logic   accept1;

  // Arbitration and next state; grants are gated by RESET so they drop at once.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!RESET) begin
          if (req0 && req1) begin
            gnt0 = last;
            gnt1 = !last;
          end else if (req0) begin
            gnt0 = 1'b1;
          end else if (req1) begin
            gnt1 = 1'b1;
          end
        end
        if ((gnt0 && req0 && !we0) || (gnt1 && req1 && !we1)) begin
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign accept0 = req0 && gnt0;
  assign accept1 = req1 && gnt1;

  // Memory drive from the winner; address and data default to port 0 when idle.
  always_comb begin
    mem_addr       = addr0;
    mem_write_data = wdata0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    if (gnt1) begin
      mem_addr       = addr1;
      mem_write_data = wdata1;
      mem_write      = we1;
      mem_read       = !we1;
    end else if (gnt0) begin
      mem_write      = we0;
      mem_read       = !we0;
    end
  end

  assign busy = (state == RD_WAIT);

  // State register, round-robin pointer and read owner.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      last  <= 1'b1;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept0) begin
        last <= 1'b0;
        if (!we0) owner <= 1'b0;
      end else if (accept1) begin
        last <= 1'b1;
        if (!we1) owner <= 1'b1;
      end
    end
  end

  // Read return: capture dout into the owner's register with a one-cycle pulse.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      if (state == RD_WAIT) begin
        if (owner) begin
          rdata1  <= mem_dout;
          rvalid1 <= 1'b1;
        end else begin
          rdata0  <= mem_dout;
          rvalid0 <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural dmem attached.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          RESET;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic          mem_write, mem_read, busy;
  logic [DW-1:0] mem_dout;

  logic [DW-1:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.DATA_WIDTH(DW), .MEM_DEPTH(1024)) dut (
    .clk(clk), .RESET(RESET),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_dout(mem_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // dmem model: synchronous write, registered read, dout held when not reading
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_write_data;
    if (mem_read) mem_dout <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h3FF] = 32'h1234_5678;
    mem_dout = '0;
    RESET = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b1; we1 = 1'b0; addr1 = '0; wdata1 = '0;

    // reset state, grants forced low even with requests pending
    @(negedge clk);
    chk("rst_gnt0", {31'b0, gnt0}, 0);
    chk("rst_gnt1", {31'b0, gnt1}, 0);
    chk("rst_mem_read", {31'b0, mem_read}, 0);
    chk("rst_rvalid0", {31'b0, rvalid0}, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    RESET = 1'b0;
    tick();

    // 1: write then read on port 0
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h010; wdata0 = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t1_wr_gnt0", {31'b0, gnt0}, 1);
    chk("t1_wr_gnt1", {31'b0, gnt1}, 0);
    chk("t1_wr_mem_write", {31'b0, mem_write}, 1);
    chk("t1_wr_mem_read", {31'b0, mem_read}, 0);
    chk("t1_wr_mem_addr", {22'b0, mem_addr}, 32'h010);
    chk("t1_wr_mem_wdata", mem_write_data, 32'hDEAD_BEEF);
    tick();
    we0 = 1'b0;
    @(negedge clk);
    chk("t1_rd_gnt0", {31'b0, gnt0}, 1);
    chk("t1_rd_mem_read", {31'b0, mem_read}, 1);
    chk("t1_rd_mem_write", {31'b0, mem_write}, 0);
    tick();
    req0 = 1'b0;
    @(negedge clk);
    chk("t1_wait_busy", {31'b0, busy}, 1);
    chk("t1_wait_rvalid0", {31'b0, rvalid0}, 0);
    tick();
    @(negedge clk);
    chk("t1_rvalid0", {31'b0, rvalid0}, 1);
    chk("t1_rdata0", rdata0, 32'hDEAD_BEEF);
    chk("t1_busy_done", {31'b0, busy}, 0);
    tick();
    @(negedge clk);
    chk("t1_rvalid0_pulse", {31'b0, rvalid0}, 0);
    chk("t1_rdata0_hold", rdata0, 32'hDEAD_BEEF);

    // 2: back-to-back writes on port 1, read back on port 0
    req1 = 1'b1; we1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr1 = AW'(i); wdata1 = DW'(i * 3);
      @(negedge clk);
      chk("t2_wr_gnt1", {31'b0, gnt1}, 1);
      chk("t2_wr_mem_write", {31'b0, mem_write}, 1);
      tick();
    end
    req1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t2_rd_gnt0", {31'b0, gnt0}, 1);
      if (i > 0) begin
        chk("t2_rvalid0", {31'b0, rvalid0}, 1);
        chk("t2_rdata0", rdata0, DW'((i - 1) * 3));
      end
      tick();
      @(negedge clk);
      chk("t2_wait_gnt0", {31'b0, gnt0}, 0);
      chk("t2_wait_busy", {31'b0, busy}, 1);
      tick();
      addr0 = AW'(i + 1);
      if (i == 7) req0 = 1'b0;
    end
    @(negedge clk);
    chk("t2_last_rvalid0", {31'b0, rvalid0}, 1);
    chk("t2_last_rdata0", rdata0, 32'd21);
    chk("t2_rdata1_untouched", rdata1, 0);

    // 3: contending reads from reset alternate 0,1,0,1
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_gnt0", {31'b0, gnt0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("t3_gnt1", {31'b0, gnt1}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("t3_excl_gnt", {31'b0, gnt0 & gnt1}, 0);
      chk("t3_excl_strobe", {31'b0, mem_write & mem_read}, 0);
      if (k > 0) begin
        chk("t3_rvalid0", {31'b0, rvalid0}, (k % 2 == 1) ? 32'd1 : 32'd0);
        chk("t3_rvalid1", {31'b0, rvalid1}, (k % 2 == 0) ? 32'd1 : 32'd0);
        if (k % 2 == 1) chk("t3_rdata0", rdata0, 0);
        else            chk("t3_rdata1", rdata1, 3);
      end
      tick();
      @(negedge clk);
      chk("t3_wait_busy", {31'b0, busy}, 1);
      chk("t3_wait_gnt", {30'b0, gnt1, gnt0}, 0);
      chk("t3_wait_rvalid", {30'b0, rvalid1, rvalid0}, 0);
      tick();
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    @(negedge clk);
    chk("t3_end_rvalid1", {31'b0, rvalid1}, 1);
    chk("t3_end_rvalid0", {31'b0, rvalid0}, 0);
    chk("t3_end_rdata1", rdata1, 3);

    // 4: port 0 read of 0x3FF while port 1 holds a write
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h3FF;
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'h020; wdata1 = 32'h0000_CAFE;
    @(negedge clk);
    chk("t4_gnt0", {31'b0, gnt0}, 1);
    chk("t4_gnt1_blocked", {31'b0, gnt1}, 0);
    tick();
    req0 = 1'b0;
    @(negedge clk);
    chk("t4_wait_gnt1", {31'b0, gnt1}, 0);
    chk("t4_wait_busy", {31'b0, busy}, 1);
    tick();
    @(negedge clk);
    chk("t4_gnt1", {31'b0, gnt1}, 1);
    chk("t4_rvalid0", {31'b0, rvalid0}, 1);
    chk("t4_rdata0", rdata0, 32'h1234_5678);
    chk("t4_mem_write", {31'b0, mem_write}, 1);
    chk("t4_mem_addr", {22'b0, mem_addr}, 32'h020);
    chk("t4_rdata1_hold", rdata1, 3);
    chk("t4_rvalid1", {31'b0, rvalid1}, 0);
    tick();
    req1 = 1'b0;
    @(negedge clk);
    chk("t4_rvalid0_pulse", {31'b0, rvalid0}, 0);
    chk("t4_rdata1_after", rdata1, 3);

    // 5: asynchronous reset during RD_WAIT
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h020;
    @(negedge clk);
    chk("t5_gnt0", {31'b0, gnt0}, 1);
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h3FF;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h001;
    #1;
    chk("t5_busy_before", {31'b0, busy}, 1);
    RESET = 1'b1;
    #1;
    chk("t5_busy", {31'b0, busy}, 0);
    chk("t5_gnt", {30'b0, gnt1, gnt0}, 0);
    chk("t5_strobes", {30'b0, mem_write, mem_read}, 0);
    chk("t5_rvalid", {30'b0, rvalid1, rvalid0}, 0);
    chk("t5_rdata0", rdata0, 0);
    chk("t5_rdata1", rdata1, 0);
    tick();
    chk("t5_rvalid_in_rst", {30'b0, rvalid1, rvalid0}, 0);
    RESET = 1'b0;
    @(negedge clk);
    chk("t5_post_gnt0", {31'b0, gnt0}, 1);
    chk("t5_post_gnt1", {31'b0, gnt1}, 0);
    chk("t5_post_rvalid", {30'b0, rvalid1, rvalid0}, 0);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("t5_post_busy", {31'b0, busy}, 1);
    tick();
    @(negedge clk);
    chk("t5_post_rvalid0", {31'b0, rvalid0}, 1);
    chk("t5_post_rdata0", rdata0, 32'h1234_5678);
    chk("t5_post_rdata1", rdata1, 0);

    // 6: idle cycles keep strobes low and read data held
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("t6_mem_write", {31'b0, mem_write}, 0);
      chk("t6_mem_read", {31'b0, mem_read}, 0);
      chk("t6_rdata0", rdata0, 32'h1234_5678);
      chk("t6_rdata1", rdata1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
